cpu_control: RTL and testbench

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_decoder.sv | 43 ++++
 rtl/cpu_control.sv | 106 ++++++++++
 tb/tb_cpu_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the cpu_control slice.
// Opcodes, ALU selects, FSM states and the latched instruction fields.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Only the instruction bits that drive outputs are kept.
  typedef struct packed {
    logic [7:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [7:0] src2;
  } ir_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode-to-control mapping.
// Undefined opcodes clear valid and never request a write.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] op_i,
  output logic [2:0] aluop_o,
  output logic       imm_sel_o,
  output logic       neg_sel_o,
  output logic       wr_o,
  output logic       halt_o,
  output logic       valid_o
);

  always_comb begin
    aluop_o   = ALU_FWD;
    imm_sel_o = 1'b0;
    neg_sel_o = 1'b0;
    wr_o      = 1'b1;
    halt_o    = 1'b0;
    valid_o   = 1'b1;
    unique case (1'b1)
      op_i == OP_LOADI: imm_sel_o = 1'b1;
      op_i == OP_MOV:   aluop_o = ALU_FWD;
      op_i == OP_ADD:   aluop_o = ALU_ADD;
      op_i == OP_SUB: begin
        aluop_o   = ALU_ADD;
        neg_sel_o = 1'b1;
      end
      op_i == OP_AND:   aluop_o = ALU_AND;
      op_i == OP_OR:    aluop_o = ALU_OR;
      op_i == OP_HALT: begin
        wr_o   = 1'b0;
        halt_o = 1'b1;
      end
      default: begin
        wr_o    = 1'b0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle FETCH/DECODE/EXEC control unit with HALT.
// Decode outputs come from the latched IR and are visible in DECODE and EXEC.
module cpu_control
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_BUSYWAIT,
  output logic [31:0] PC,
  output logic        INSTR_READ,
  output logic [2:0]  WRITEREG,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic        WRITE_EN,
  output logic [2:0]  ALUOP,
  output logic [7:0]  IMM,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic        ILLEGAL,
  output logic        HALTED
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ir_t         ir_q, ir_d;

  logic [2:0] dec_aluop;
  logic       dec_imm_sel;
  logic       dec_neg_sel;
  logic       dec_wr;
  logic       dec_halt;
  logic       dec_valid;

  logic unused_bits;
  assign unused_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

  cpu_decoder u_dec (
    .op_i      (ir_q.op),
    .aluop_o   (dec_aluop),
    .imm_sel_o (dec_imm_sel),
    .neg_sel_o (dec_neg_sel),
    .wr_o      (dec_wr),
    .halt_o    (dec_halt),
    .valid_o   (dec_valid)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_FETCH: begin
        if (!INSTR_BUSYWAIT) begin
          ir_d = '{op:   INSTRUCTION[31:24],
                   rd:   INSTRUCTION[18:16],
                   rs1:  INSTRUCTION[10:8],
                   src2: INSTRUCTION[7:0]};
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = dec_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
    endcase
  end

  logic in_fetch, in_exec, dec_vis;
  assign in_fetch = (state_q == S_FETCH);
  assign in_exec  = (state_q == S_EXEC);
  assign dec_vis  = (state_q == S_DECODE) || in_exec;

  // Strobes are cut by RESET so an in-flight EXEC never writes.
  assign INSTR_READ = in_fetch && !RESET;
  assign WRITE_EN   = in_exec && dec_wr && !RESET;
  assign ILLEGAL    = in_exec && !dec_valid && !RESET;
  assign HALTED     = (state_q == S_HALT);
  assign PC         = pc_q;

  assign WRITEREG = dec_vis ? ir_q.rd        : 3'd0;
  assign READREG1 = dec_vis ? ir_q.rs1       : 3'd0;
  assign READREG2 = dec_vis ? ir_q.src2[2:0] : 3'd0;
  assign IMM      = dec_vis ? ir_q.src2      : 8'd0;
  assign ALUOP    = dec_vis ? dec_aluop      : ALU_FWD;
  assign IMM_SEL  = dec_vis && dec_imm_sel;
  assign NEG_SEL  = dec_vis && dec_neg_sel;

endmodule

// File: tb/tb_cpu_control.sv
// Scenario bench for cpu_control.
// Expected results are queued at stimulus time and popped at EXEC.
module tb_cpu_control;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic        INSTR_BUSYWAIT = 1'b0;
  logic [31:0] PC;
  logic        INSTR_READ, WRITE_EN, IMM_SEL, NEG_SEL, ILLEGAL, HALTED;
  logic [2:0]  WRITEREG, READREG1, READREG2, ALUOP;
  logic [7:0]  IMM;

  cpu_control dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .INSTR_BUSYWAIT(INSTR_BUSYWAIT), .PC(PC), .INSTR_READ(INSTR_READ),
    .WRITEREG(WRITEREG), .READREG1(READREG1), .READREG2(READREG2),
    .WRITE_EN(WRITE_EN), .ALUOP(ALUOP), .IMM(IMM), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .ILLEGAL(ILLEGAL), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  wr, rr1, rr2, aluop;
    logic [7:0]  imm;
    logic        imm_sel, neg_sel, we, ill;
    logic [31:0] pc_after;
    int          reads;
  } exp_t;

  typedef struct {
    logic [2:0]  wr, rr1, rr2, aluop;
    logic [7:0]  imm;
    logic        imm_sel, neg_sel, we, ill, halted;
    logic        stable, pcchg, ill_after;
    logic [31:0] pc_after;
    int          reads, early_we;
  } obs_t;

  exp_t        sb[$];
  int          npass = 0;
  int          ntot = 0;
  logic [31:0] exp_pc = '0;

  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc, int busy);
    exp_t e;
    e.wr = ins[18:16]; e.rr1 = ins[10:8]; e.rr2 = ins[2:0];
    e.imm = ins[7:0]; e.aluop = 3'b000; e.imm_sel = 0; e.neg_sel = 0;
    e.we = 1; e.ill = 0; e.pc_after = pc + 32'd4; e.reads = busy + 1;
    case (ins[31:24])
      8'h00: e.imm_sel = 1;
      8'h01: ;
      8'h02: e.aluop = 3'b001;
      8'h03: begin e.aluop = 3'b001; e.neg_sel = 1; end
      8'h04: e.aluop = 3'b010;
      8'h05: e.aluop = 3'b011;
      8'hFF: begin e.we = 0; e.pc_after = pc; end
      default: begin e.we = 0; e.ill = 1; end
    endcase
    return e;
  endfunction

  // Starts just after a negedge with the DUT in FETCH.
  task automatic run_instr(input logic [31:0] ins, input int busy,
                           output obs_t o);
    logic [31:0] pc0;
    logic [27:0] snap;
    o = '{default: '0};
    pc0 = PC;
    for (int k = 0; k <= busy; k++) begin
      o.reads += int'(INSTR_READ);
      o.early_we += int'(WRITE_EN);
      if (PC !== pc0) o.pcchg = 1;
      INSTR_BUSYWAIT = (k < busy);
      INSTRUCTION = (k < busy) ? $urandom : ins;
      @(negedge CLK);
    end
    o.reads += int'(INSTR_READ);
    o.early_we += int'(WRITE_EN);
    if (PC !== pc0) o.pcchg = 1;
    snap = {WRITEREG, READREG1, READREG2, IMM, ALUOP, IMM_SEL, NEG_SEL};
    INSTRUCTION = $urandom;
    @(negedge CLK);
    o.reads += int'(INSTR_READ);
    if (PC !== pc0) o.pcchg = 1;
    o.stable = (snap === {WRITEREG, READREG1, READREG2, IMM, ALUOP,
                          IMM_SEL, NEG_SEL});
    o.wr = WRITEREG; o.rr1 = READREG1; o.rr2 = READREG2; o.imm = IMM;
    o.aluop = ALUOP; o.imm_sel = IMM_SEL; o.neg_sel = NEG_SEL;
    o.we = WRITE_EN; o.ill = ILLEGAL; o.halted = HALTED;
    @(negedge CLK);
    o.pc_after = PC;
    o.ill_after = ILLEGAL;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    @(negedge CLK); @(negedge CLK);
    ntot++; if (PC !== 32'h0) $display("FAIL rst_pc got %h exp 0", PC); else npass++;
    ntot++; if ({INSTR_READ, WRITE_EN, ILLEGAL, HALTED, IMM_SEL, NEG_SEL} !== 6'b0)
      $display("FAIL rst_strobes got %b exp 0",
               {INSTR_READ, WRITE_EN, ILLEGAL, HALTED, IMM_SEL, NEG_SEL});
    else npass++;
    ntot++; if ({WRITEREG, READREG1, READREG2, ALUOP, IMM} !== 20'h0)
      $display("FAIL rst_fields got %h exp 0", {WRITEREG, READREG1, READREG2, ALUOP, IMM});
    else npass++;
    RESET = 1'b0;
    #1;
    ntot++; if (INSTR_READ !== 1'b1) $display("FAIL rst_read got %b exp 1", INSTR_READ); else npass++;
    exp_pc = 32'h0;
  endtask

  task automatic test_loadi();
    obs_t o; exp_t e;
    sb.push_back(model(32'h0003_005A, exp_pc, 0));
    run_instr(32'h0003_005A, 0, o);
    e = sb.pop_front();
    ntot++; if (o.wr !== e.wr) $display("FAIL loadi_wr got %0d exp %0d", o.wr, e.wr); else npass++;
    ntot++; if (o.imm !== e.imm) $display("FAIL loadi_imm got %h exp %h", o.imm, e.imm); else npass++;
    ntot++; if (o.imm_sel !== e.imm_sel) $display("FAIL loadi_isel got %b exp %b", o.imm_sel, e.imm_sel); else npass++;
    ntot++; if (o.we !== e.we || o.early_we != 0)
      $display("FAIL loadi_we got %b/%0d exp %b/0", o.we, o.early_we, e.we);
    else npass++;
    ntot++; if (o.pc_after !== e.pc_after) $display("FAIL loadi_pc got %h exp %h", o.pc_after, e.pc_after); else npass++;
    exp_pc = e.pc_after;
  endtask

  task automatic test_sub();
    obs_t o; exp_t e;
    sb.push_back(model(32'h0301_0204, exp_pc, 0));
    run_instr(32'h0301_0204, 0, o);
    e = sb.pop_front();
    ntot++; if (o.aluop !== e.aluop || o.neg_sel !== e.neg_sel)
      $display("FAIL sub_alu got %b/%b exp %b/%b", o.aluop, o.neg_sel, e.aluop, e.neg_sel);
    else npass++;
    ntot++; if ({o.wr, o.rr1, o.rr2} !== {e.wr, e.rr1, e.rr2})
      $display("FAIL sub_regs got %0d,%0d,%0d exp %0d,%0d,%0d", o.wr, o.rr1, o.rr2, e.wr, e.rr1, e.rr2);
    else npass++;
    ntot++; if (o.stable !== 1'b1) $display("FAIL sub_stable got %b exp 1", o.stable); else npass++;
    ntot++; if (o.pc_after !== e.pc_after) $display("FAIL sub_pc got %h exp %h", o.pc_after, e.pc_after); else npass++;
    exp_pc = e.pc_after;
  endtask

  task automatic test_busywait();
    obs_t o; exp_t e;
    sb.push_back(model(32'h02FA_0B0D, exp_pc, 5));
    run_instr(32'h02FA_0B0D, 5, o);
    e = sb.pop_front();
    ntot++; if (o.reads != e.reads) $display("FAIL bw_reads got %0d exp %0d", o.reads, e.reads); else npass++;
    ntot++; if (o.early_we != 0) $display("FAIL bw_early_we got %0d exp 0", o.early_we); else npass++;
    ntot++; if (o.pcchg !== 1'b0) $display("FAIL bw_pc_frozen got %b exp 0", o.pcchg); else npass++;
    ntot++; if ({o.wr, o.rr1, o.rr2, o.we} !== {e.wr, e.rr1, e.rr2, e.we})
      $display("FAIL bw_upper_bits got %h exp %h", {o.wr, o.rr1, o.rr2, o.we}, {e.wr, e.rr1, e.rr2, e.we});
    else npass++;
    ntot++; if (o.pc_after !== e.pc_after) $display("FAIL bw_pc got %h exp %h", o.pc_after, e.pc_after); else npass++;
    exp_pc = e.pc_after;
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    sb.push_back(model(32'h7E01_0203, exp_pc, 0));
    run_instr(32'h7E01_0203, 0, o);
    e = sb.pop_front();
    ntot++; if (o.ill !== e.ill || o.ill_after !== 1'b0)
      $display("FAIL ill_pulse got %b%b exp %b0", o.ill, o.ill_after, e.ill);
    else npass++;
    ntot++; if (o.we !== e.we || o.early_we != 0) $display("FAIL ill_we got %b exp %b", o.we, e.we); else npass++;
    ntot++; if (o.pc_after !== e.pc_after) $display("FAIL ill_pc got %h exp %h", o.pc_after, e.pc_after); else npass++;
    exp_pc = e.pc_after;
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    obs_t o; exp_t e;
    logic [31:0] p;
    prog[0] = 32'h0407_0506; prog[1] = 32'h0500_0102; prog[2] = 32'h0106_0300;
    p = exp_pc;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(prog[i], p, i));
      p = p + 32'd4;
    end
    for (int i = 0; i < 3; i++) begin
      run_instr(prog[i], i, o);
      e = sb.pop_front();
      ntot++; if ({o.wr, o.rr1, o.rr2, o.aluop, o.imm_sel, o.neg_sel, o.we, o.ill}
                  !== {e.wr, e.rr1, e.rr2, e.aluop, e.imm_sel, e.neg_sel, e.we, e.ill})
        $display("FAIL b2b_ctl[%0d] got %h exp %h", i,
                 {o.wr, o.rr1, o.rr2, o.aluop, o.imm_sel, o.neg_sel, o.we, o.ill},
                 {e.wr, e.rr1, e.rr2, e.aluop, e.imm_sel, e.neg_sel, e.we, e.ill});
      else npass++;
      ntot++; if (o.pc_after !== e.pc_after || o.reads != e.reads)
        $display("FAIL b2b_pc[%0d] got %h/%0d exp %h/%0d", i, o.pc_after, o.reads, e.pc_after, e.reads);
      else npass++;
      exp_pc = e.pc_after;
    end
    ntot++; if (sb.size() != 0) $display("FAIL b2b_sb_left got %0d exp 0", sb.size()); else npass++;
  endtask

  task automatic test_reset_exec();
    INSTR_BUSYWAIT = 1'b0;
    INSTRUCTION = 32'h0201_0203;
    @(negedge CLK);
    @(negedge CLK);
    ntot++; if (WRITE_EN !== 1'b1) $display("FAIL rx_exec_we got %b exp 1", WRITE_EN); else npass++;
    RESET = 1'b1;
    #1;
    ntot++; if (WRITE_EN !== 1'b0) $display("FAIL rx_we_cut got %b exp 0", WRITE_EN); else npass++;
    @(negedge CLK);
    ntot++; if (PC !== 32'h0) $display("FAIL rx_pc got %h exp 0", PC); else npass++;
    RESET = 1'b0;
    #1;
    ntot++; if (INSTR_READ !== 1'b1) $display("FAIL rx_read got %b exp 1", INSTR_READ); else npass++;
    exp_pc = 32'h0;
  endtask

  task automatic test_halt();
    obs_t o; exp_t e;
    int bad;
    sb.push_back(model(32'hFF00_0000, exp_pc, 0));
    run_instr(32'hFF00_0000, 0, o);
    e = sb.pop_front();
    ntot++; if (o.halted !== 1'b1 || o.we !== e.we)
      $display("FAIL halt_enter got %b/%b exp 1/%b", o.halted, o.we, e.we);
    else npass++;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (PC !== e.pc_after || HALTED !== 1'b1 || INSTR_READ || WRITE_EN || ILLEGAL) bad++;
      @(negedge CLK);
    end
    ntot++; if (bad != 0) $display("FAIL halt_frozen got %0d bad cycles exp 0", bad); else npass++;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    ntot++; if (PC !== 32'h0 || HALTED !== 1'b0 || INSTR_READ !== 1'b1)
      $display("FAIL halt_exit got pc=%h h=%b r=%b exp pc=0 h=0 r=1", PC, HALTED, INSTR_READ);
    else npass++;
    exp_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_loadi();
    test_sub();
    test_busywait();
    test_illegal();
    test_back_to_back();
    test_reset_exec();
    test_loadi();
    test_halt();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
